lvds_capture_ctrl: RTL and testbench

LVDS_CAPTURE_CTRL -- requirements
Module: lvds_capture_ctrl

---
 rtl/lvds_capture_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_lvds_capture_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_capture_ctrl.sv
// Frame capture from an LVDS pixel stream into a small AXI-Stream style output FIFO.
// Optional macro LVDS_CAP_TESTPAT_EN enables the line/pixel counter test pattern (cfg_testpat).
module lvds_capture_ctrl #(
  parameter int DW         = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK_IN,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          group_in,
  input  logic          cap_start,
  input  logic          cap_stop,
  input  logic [11:0]   cfg_pix,
  input  logic [11:0]   cfg_lines,
  input  logic          cfg_testpat,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tuser,
  output logic          m_tlast,
  output logic          busy,
  output logic          done,
  output logic          err_short,
  output logic          ovf,
  output logic [7:0]    ovf_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t          r_state;
  logic            r_group_d;
  logic [11:0]     r_pix_lim;
  logic [11:0]     r_line_lim;
  logic [11:0]     r_pix_cnt;
  logic [11:0]     r_line_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_err_short;
  logic            r_ovf;
  logic [7:0]      r_ovf_cnt;

  logic [DW+1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_tvalid;
  logic [DW-1:0]   r_tdata;
  logic            r_tuser;
  logic            r_tlast;

  logic            w_rise;
  logic            w_fall;
  logic            w_in_line;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr_en;
  logic            w_drop;
  logic            w_sof;
  logic            w_eol;
  logic            w_mem_avail;
  logic [11:0]     w_line_next;
  logic [DW-1:0]   w_pix_data;

  assign w_rise      = group_in & ~r_group_d;
  assign w_fall      = ~group_in & r_group_d;
  assign w_in_line   = r_pix_cnt < r_pix_lim;
  // The only pixel pushed from ARM is the first pixel of the frame.
  assign w_push      = ~cap_stop & (((r_state == ARM) & w_rise) |
                                    ((r_state == CAPTURE) & group_in & w_in_line));
  assign w_pop       = r_tvalid & m_tready;
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_wr_en     = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_sof       = (r_state == ARM);
  assign w_eol       = (r_pix_cnt == (r_pix_lim - 12'd1));
  assign w_line_next = r_line_cnt + 12'd1;
  // Entries still in memory exclude the one already presented on the output registers.
  assign w_mem_avail = r_tvalid ? (r_count > CW'(1)) : (r_count != CW'(0));

`ifdef LVDS_CAP_TESTPAT_EN
  assign w_pix_data = cfg_testpat ? {r_line_cnt[5:0], r_pix_cnt[DW-7:0]} : data_in;
`else
  logic w_unused_testpat;
  assign w_unused_testpat = cfg_testpat;
  assign w_pix_data       = data_in;
`endif

  // Capture FSM with line/pixel counters and status flags.
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_group_d   <= 1'b0;
      r_pix_lim   <= 12'd0;
      r_line_lim  <= 12'd0;
      r_pix_cnt   <= 12'd0;
      r_line_cnt  <= 12'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_ovf       <= 1'b0;
      r_ovf_cnt   <= 8'd0;
    end else begin
      r_group_d <= group_in;
      r_done    <= 1'b0;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
      case (r_state)
        IDLE: begin
          if (cap_start && !cap_stop && (cfg_pix != 12'd0) && (cfg_lines != 12'd0)) begin
            r_pix_lim   <= cfg_pix;
            r_line_lim  <= cfg_lines;
            r_pix_cnt   <= 12'd0;
            r_line_cnt  <= 12'd0;
            r_err_short <= 1'b0;
            r_ovf       <= 1'b0;
            r_ovf_cnt   <= 8'd0;
            r_busy      <= 1'b1;
            r_state     <= ARM;
          end
        end
        ARM: begin
          if (cap_stop) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_rise) begin
            r_pix_cnt <= 12'd1;
            r_state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_stop) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            if (group_in && w_in_line) r_pix_cnt <= r_pix_cnt + 12'd1;
            if (w_fall) begin
              if (w_in_line) r_err_short <= 1'b1;
              r_pix_cnt  <= 12'd0;
              r_line_cnt <= w_line_next;
              if (w_line_next == r_line_lim) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and the registered output beat.
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (!r_tvalid || m_tready) begin
        if (w_mem_avail) begin
          {r_tuser, r_tlast, r_tdata} <= r_mem[r_rd_ptr];
          r_tvalid <= 1'b1;
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end else begin
          r_tvalid <= 1'b0;
        end
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until a pointer makes them visible.
  always_ff @(posedge CLK_IN) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {w_sof, w_eol, w_pix_data};
  end

  assign m_tdata   = r_tdata;
  assign m_tvalid  = r_tvalid;
  assign m_tuser   = r_tuser;
  assign m_tlast   = r_tlast;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_short = r_err_short;
  assign ovf       = r_ovf;
  assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_lvds_capture_ctrl.sv
// Directed testbench for lvds_capture_ctrl: frame table plus hand-written corner sequences.
module tb_lvds_capture_ctrl;
  localparam int DW = 15;

  logic          CLK_IN = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          group_in, cap_start, cap_stop, cfg_testpat, m_tready;
  logic [11:0]   cfg_pix, cfg_lines;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast, busy, done, err_short, ovf;
  logic [7:0]    ovf_cnt;

  lvds_capture_ctrl #(.DW(DW), .FIFO_DEPTH(4)) dut (
    .CLK_IN(CLK_IN), .rst_n(rst_n), .data_in(data_in), .group_in(group_in),
    .cap_start(cap_start), .cap_stop(cap_stop), .cfg_pix(cfg_pix), .cfg_lines(cfg_lines),
    .cfg_testpat(cfg_testpat), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .busy(busy), .done(done),
    .err_short(err_short), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [DW+1:0] beats[$];

  // Beats are recorded half a cycle before the edge that pops them.
  always @(negedge CLK_IN) begin
    if (rst_n && m_tvalid && m_tready) beats.push_back({m_tuser, m_tlast, m_tdata});
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic start_cap(input logic [11:0] p, input logic [11:0] l);
    cfg_pix = p; cfg_lines = l; cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    tick();
  endtask

  task automatic drive_line(input int n, input int tag);
    for (int i = 0; i < n; i++) begin
      group_in = 1'b1; data_in = DW'(tag + i);
      tick();
    end
    group_in = 1'b0; data_in = {DW{1'b1}};
    tick();
    tick();
  endtask

  typedef struct {
    logic [11:0] pix;
    logic [11:0] lines;
    int len0, len1, len2;
    int exp_beats;
    int exp_lasts;
    logic exp_busy;
    logic exp_err;
    int exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base, d0, k, nl;
    int lens[3];
    logic first;
    logic [DW+1:0] exp_beat;
    logic [DW-1:0] exp_d;

    vecs[0] = '{12'd4, 12'd2, 4, 4, 0, 8, 2, 1'b1, 1'b0, 1};
    vecs[1] = '{12'd0, 12'd2, 4, 4, 0, 0, 0, 1'b0, 1'b0, 0};
    vecs[2] = '{12'd4, 12'd2, 2, 4, 0, 6, 1, 1'b1, 1'b1, 1};
    vecs[3] = '{12'd3, 12'd1, 5, 0, 0, 3, 1, 1'b1, 1'b0, 1};
    vecs[4] = '{12'd1, 12'd3, 1, 2, 1, 3, 3, 1'b1, 1'b0, 1};

    rst_n = 1'b0; data_in = '0; group_in = 1'b0; cap_start = 1'b0; cap_stop = 1'b0;
    cfg_pix = 12'd0; cfg_lines = 12'd0; cfg_testpat = 1'b0; m_tready = 1'b1;
    #12;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, '0);
    check("rst_flags", {m_tuser, m_tlast, busy, done, err_short, ovf}, 6'd0);
    check("rst_ovf_cnt", ovf_cnt, 8'd0);
    @(negedge CLK_IN);
    rst_n = 1'b1;
    tick();

    // Start and stop together: stop wins, capture is not armed.
    cfg_pix = 12'd4; cfg_lines = 12'd1; cap_start = 1'b1; cap_stop = 1'b1;
    tick();
    cap_start = 1'b0; cap_stop = 1'b0;
    check("start_stop_busy", busy, 1'b0);
    tick();

    for (int e = 0; e < 5; e++) begin
      base = beats.size(); d0 = done_cnt;
      lens = '{vecs[e].len0, vecs[e].len1, vecs[e].len2};
      m_tready = 1'b1;
      start_cap(vecs[e].pix, vecs[e].lines);
      check($sformatf("v%0d_busy", e), busy, vecs[e].exp_busy);
      for (int l = 0; l < int'(vecs[e].lines); l++) drive_line(lens[l], e * 256 + l * 16);
      repeat (6) tick();
      check($sformatf("v%0d_nbeats", e), beats.size() - base, vecs[e].exp_beats);
      k = base; first = 1'b1; nl = 0;
      for (int l = 0; l < int'(vecs[e].lines); l++) begin
        for (int p = 0; p < lens[l]; p++) begin
          if (p < int'(vecs[e].pix)) begin
            exp_beat = {first, (p == int'(vecs[e].pix) - 1), DW'(e * 256 + l * 16 + p)};
            if (k < beats.size()) check($sformatf("v%0d_beat%0d", e, k - base), beats[k], exp_beat);
            k++;
            first = 1'b0;
          end
        end
      end
      for (int i = base; i < beats.size(); i++) nl += int'(beats[i][DW]);
      check($sformatf("v%0d_lasts", e), nl, vecs[e].exp_lasts);
      check($sformatf("v%0d_err", e), err_short, vecs[e].exp_err);
      check($sformatf("v%0d_done", e), done_cnt - d0, vecs[e].exp_done);
      check($sformatf("v%0d_ovf", e), ovf, 1'b0);
      check($sformatf("v%0d_idle", e), busy, 1'b0);
    end

    // Overflow: 7-pixel line into a 4-deep FIFO with the sink stalled.
    base = beats.size();
    m_tready = 1'b0;
    start_cap(12'd8, 12'd1);
    drive_line(7, 'h500);
    check("ovf_flag", ovf, 1'b1);
    check("ovf_cnt", ovf_cnt, 8'd3);
    check("ovf_err_short", err_short, 1'b1);
    check("ovf_head", {m_tvalid, m_tuser, m_tlast, m_tdata}, {3'b110, DW'('h500)});
    tick(); tick();
    check("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, {3'b110, DW'('h500)});
    m_tready = 1'b1;
    repeat (8) tick();
    check("ovf_nbeats", beats.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < beats.size())
        check($sformatf("ovf_beat%0d", i), beats[base + i], {(i == 0), 1'b0, DW'('h500 + i)});

    // Start while group_in is already high: wait for a fresh line start.
    base = beats.size();
    cfg_pix = 12'd2; cfg_lines = 12'd1;
    group_in = 1'b1; data_in = DW'('h600); cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      data_in = DW'('h600 + i);
      tick();
    end
    check("armhigh_busy", busy, 1'b1);
    check("armhigh_novalid", m_tvalid, 1'b0);
    group_in = 1'b0;
    tick();
    drive_line(2, 'h610);
    repeat (4) tick();
    check("armhigh_nbeats", beats.size() - base, 2);
    if (beats.size() - base >= 2) begin
      check("armhigh_beat0", beats[base], {2'b10, DW'('h610)});
      check("armhigh_beat1", beats[base + 1], {2'b01, DW'('h611)});
    end

    // cap_stop mid-line with two beats buffered.
    base = beats.size(); d0 = done_cnt;
    m_tready = 1'b0;
    start_cap(12'd2, 12'd2);
    group_in = 1'b1; data_in = DW'('h700); tick();
    data_in = DW'('h701); tick();
    data_in = DW'('h702); cap_stop = 1'b1; tick();
    cap_stop = 1'b0;
    check("stop_busy", busy, 1'b0);
    group_in = 1'b0;
    tick();
    m_tready = 1'b1;
    repeat (4) tick();
    check("stop_nbeats", beats.size() - base, 2);
    if (beats.size() - base >= 2) begin
      check("stop_beat0", beats[base], {2'b10, DW'('h700)});
      check("stop_beat1", beats[base + 1], {2'b01, DW'('h701)});
    end
    check("stop_nodone", done_cnt - d0, 0);

    // Reset mid-line discards buffered data; a new cap_start is required afterwards.
    base = beats.size();
    m_tready = 1'b0;
    start_cap(12'd8, 12'd1);
    group_in = 1'b1; data_in = DW'('h800); tick();
    data_in = DW'('h801); tick();
    check("rst_pre_valid", m_tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {m_tvalid, busy}, 2'b00);
    check("rst_mid_data", m_tdata, '0);
    #2 rst_n = 1'b1;
    group_in = 1'b0;
    tick();
    m_tready = 1'b1;
    drive_line(3, 'h810);
    repeat (4) tick();
    check("rst_need_start", {busy, m_tvalid}, 2'b00);
    check("rst_no_beats", beats.size() - base, 0);

    // Test-pattern select: counter pattern when the feature is built in, else raw data.
    base = beats.size();
    cfg_testpat = 1'b1; m_tready = 1'b1;
    start_cap(12'd3, 12'd2);
    drive_line(3, 'h900);
    drive_line(3, 'h910);
    repeat (4) tick();
    cfg_testpat = 1'b0;
    check("tp_nbeats", beats.size() - base, 6);
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 3; p++) begin
`ifdef LVDS_CAP_TESTPAT_EN
        exp_d = DW'((l << (DW - 6)) | p);
`else
        exp_d = DW'('h900 + l * 16 + p);
`endif
        if (base + l * 3 + p < beats.size())
          check($sformatf("tp_l%0d_p%0d", l, p), beats[base + l * 3 + p],
                {(l == 0 && p == 0), (p == 2), exp_d});
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
